// File: rtl/dds_pkg.sv
// dds_pkg: constants shared by the DDS tuning-word UART link.
//   - tx state encoding (ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_GAP)
//   - DDS_WORD_W / DDS_WORD_BYTES: tuning word geometry
//   - DDS_CLKS_PER_BIT: default baud divider (100 MHz / 115200)
//   - word_xor(): XOR of all word bytes, used for the checksum frame
//     when FREQ_TX_CHECKSUM_EN is defined.
package dds_pkg;

  localparam int DDS_WORD_W       = 32;
  localparam int DDS_WORD_BYTES   = 4;
  localparam int DDS_CLKS_PER_BIT = 868;

  typedef logic [2:0] tx_state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  function automatic logic [7:0] word_xor(input logic [DDS_WORD_W-1:0] w);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < DDS_WORD_BYTES; i++) begin
      x = x ^ w[i*8 +: 8];
    end
    return x;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: single 8N1 byte serialiser (start bit, 8 data bits LSB
// first, stop bit), each bit CLKS_PER_BIT cycles.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   start         load data_in and begin a byte (taken in IDLE or in the
//                 final stop cycle, so bytes can be chained with no gap)
//   data_in[7:0]  byte to send
//   short_stop    end the stop bit one cycle early in the state machine;
//                 the caller's output register supplies the last cycle
//   line          unregistered serial level for this cycle
//   busy          a byte is in flight
//   done          high in the final cycle of the stop bit
//
// state    | meaning
// ST_IDLE  | line high, waiting for start
// ST_START | start bit (line low)
// ST_DATA  | data bits, shreg_q[0] on the line
// ST_STOP  | stop bit (line high)
module uart_tx_byte
  import dds_pkg::*;
#(
  parameter int CLKS_PER_BIT = DDS_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       short_stop,
  output logic       line,
  output logic       busy,
  output logic       done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_SHORT = BAUD_W'(CLKS_PER_BIT - 2);

  tx_state_t         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              short_q, short_d;
  logic              bit_end;
  logic              stop_end;

  always_comb begin
    bit_end  = (baud_q == BAUD_LAST);
    stop_end = (state_q == ST_STOP) &&
               (baud_q == (short_q ? BAUD_SHORT : BAUD_LAST));

    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    short_d = short_q;

    case (state_q)
      ST_IDLE: baud_d = '0;
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (stop_end) begin
          state_d = ST_IDLE;
          baud_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
      end
    endcase

    if (start && ((state_q == ST_IDLE) || stop_end)) begin
      state_d = ST_START;
      baud_d  = '0;
      shreg_d = data_in;
      short_d = short_stop;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      short_q <= short_d;
    end
  end

  assign line = (state_q == ST_START) ? 1'b0 :
                (state_q == ST_DATA)  ? shreg_q[0] : 1'b1;
  assign busy = (state_q != ST_IDLE);
  assign done = stop_end;

endmodule

// File: rtl/freq_word_uart_tx.sv
// freq_word_uart_tx: sends a 32-bit DDS tuning word as NUM_BYTES 8N1
// frames, byte 0 (word[7:0]) first, with GAP_BITS idle bit periods
// between bytes. One word per word_valid/word_ready handshake.
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   word_in[31:0]  tuning word, latched on accept
//   word_valid     word_in valid; ignored while word_ready=0
//   word_ready     idle, a word can be accepted
//   tx             registered serial output, idle high
//   busy           ~word_ready
//   done           one-cycle pulse as the word's last stop bit completes
// Optional feature macro: FREQ_TX_CHECKSUM_EN -- appends one frame with
// the XOR of the word bytes after the last word byte.
//
// state    | meaning
// ST_IDLE  | waiting for a word; also the final stop-bit cycle of a word
// ST_START | a byte is in flight in uart_tx_byte (start/data/stop)
// ST_GAP   | idle-high spacing between two bytes of one word
module freq_word_uart_tx
  import dds_pkg::*;
#(
  parameter int CLKS_PER_BIT = DDS_CLKS_PER_BIT,
  parameter int GAP_BITS     = 0,
  parameter int NUM_BYTES    = DDS_WORD_BYTES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DDS_WORD_W-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

`ifdef FREQ_TX_CHECKSUM_EN
  localparam int TOTAL_BYTES = NUM_BYTES + 1;
`else
  localparam int TOTAL_BYTES = NUM_BYTES;
`endif
  localparam int GAP_CLKS = GAP_BITS * CLKS_PER_BIT;
  localparam int GAP_W    = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam logic [2:0] LAST_IDX = 3'(TOTAL_BYTES - 1);

  tx_state_t             state_q, state_d;
  logic [2:0]            idx_q, idx_d;     // bytes handed to the serialiser
  logic [DDS_WORD_W-9:0] rest_q, rest_d;   // word bytes not yet handed over
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  done_q, done_d;
  logic                  tx_q, tx_d;
`ifdef FREQ_TX_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic       byte_start;
  logic [7:0] byte_data;
  logic       byte_short;
  logic       byte_line;
  logic       byte_busy;
  logic       byte_done;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk       (clk),
    .rst       (rst),
    .start     (byte_start),
    .data_in   (byte_data),
    .short_stop(byte_short),
    .line      (byte_line),
    .busy      (byte_busy),
    .done      (byte_done)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rest_d     = rest_q;
    gap_d      = gap_q;
    done_d     = 1'b0;
    byte_start = 1'b0;
    byte_data  = rest_q[7:0];
    // The last byte ends its stop bit one cycle early in the FSM: that
    // cycle is spent in ST_IDLE (done, word_ready) while tx_q still shows
    // stop, so a word accepted then starts with no idle cycle on the pin.
    byte_short = (idx_q == LAST_IDX);
`ifdef FREQ_TX_CHECKSUM_EN
    csum_d = csum_q;
    if (idx_q >= 3'(NUM_BYTES)) byte_data = csum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (word_valid) begin
          state_d    = ST_START;
          byte_start = 1'b1;
          byte_data  = word_in[7:0];
          byte_short = (LAST_IDX == 3'd0);
          idx_d      = 3'd1;
          rest_d     = word_in[DDS_WORD_W-1:8];
`ifdef FREQ_TX_CHECKSUM_EN
          csum_d     = word_xor(word_in);
`endif
        end
      end
      ST_START: begin
        if (byte_done) begin
          if (idx_q == 3'(TOTAL_BYTES)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (GAP_CLKS == 0) begin
            byte_start = 1'b1;
            idx_d      = idx_q + 3'd1;
            rest_d     = rest_q >> 8;
          end else begin
            state_d = ST_GAP;
            gap_d   = '0;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d    = ST_START;
          byte_start = 1'b1;
          idx_d      = idx_q + 3'd1;
          rest_d     = rest_q >> 8;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    tx_d = byte_busy ? byte_line : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rest_q  <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
      tx_q    <= 1'b1;
`ifdef FREQ_TX_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rest_q  <= rest_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
`ifdef FREQ_TX_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign word_ready = (state_q == ST_IDLE);
  assign busy       = ~word_ready;
  assign done       = done_q;
  assign tx         = tx_q;

endmodule

// File: tb/tb_freq_word_uart_tx.sv
// Bench for freq_word_uart_tx: dut0 (GAP_BITS=0) and dut1 (GAP_BITS=2),
// both CLKS_PER_BIT=4. Expected bytes go into exp_q when a word is
// driven; a bench uart receiver pops and compares as bytes arrive.
module tb_freq_word_uart_tx;

  localparam int CPB = 4;
  localparam int GAP = 2;
`ifdef FREQ_TX_CHECKSUM_EN
  localparam int NB_SENT = 5;
`else
  localparam int NB_SENT = 4;
`endif
  localparam int BYTE_CYC = 10 * CPB;
  localparam int FRAME0   = NB_SENT * BYTE_CYC;
  localparam int FRAME1   = NB_SENT * BYTE_CYC + (NB_SENT - 1) * GAP * CPB;
  // Counting the accept cycle as cycle 0, done is high in cycle FRAME,
  // i.e. it is first seen after the (FRAME-1)th edge following the
  // accept edge; a word offered then is accepted FRAME edges after the
  // previous accept, which makes back-to-back words contiguous on tx.
  localparam int DONE0 = FRAME0 - 1;
  localparam int DONE1 = FRAME1 - 1;

  logic        clk = 1'b0;
  logic        rst0, rst1, v0, v1;
  logic [31:0] w0, w1;
  logic        ready0, tx0, busy0, done0;
  logic        ready1, tx1, busy1, done1;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  freq_word_uart_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(0)) dut0 (
    .clk(clk), .rst(rst0), .word_in(w0), .word_valid(v0),
    .word_ready(ready0), .tx(tx0), .busy(busy0), .done(done0));

  freq_word_uart_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP)) dut1 (
    .clk(clk), .rst(rst1), .word_in(w1), .word_valid(v1),
    .word_ready(ready1), .tx(tx1), .busy(busy1), .done(done1));

  function automatic logic txv(input int sel);
    return (sel == 0) ? tx0 : tx1;
  endfunction

  function automatic logic donev(input int sel);
    return (sel == 0) ? done0 : done1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(w[i*8 +: 8]);
      x = x ^ w[i*8 +: 8];
    end
`ifdef FREQ_TX_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  // Bench receiver: waits (bounded) for a start bit, samples mid-bit.
  task automatic rx_byte(input int sel, output logic [7:0] b, output bit stop_ok,
                         output int start_cyc);
    int k;
    k = 0;
    b = 'x;
    stop_ok = 1'b0;
    start_cyc = -1;
    while (txv(sel) !== 1'b0 && k < 600) begin
      tick();
      k++;
    end
    if (k >= 600) return;
    start_cyc = cyc;
    repeat (CPB / 2) tick();
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) tick();
      b[i] = txv(sel);
    end
    repeat (CPB) tick();
    stop_ok = (txv(sel) === 1'b1);
  endtask

  // Edges after the caller's current edge until done is seen; -1 on timeout.
  task automatic count_to_done(input int sel, input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (donev(sel) === 1'b1) begin
        n = k;
        return;
      end
    end
  endtask

  task automatic rx_and_compare(input int sel, input int nbytes, input string tag);
    logic [7:0] b, e;
    bit         sok;
    int         sc;
    for (int i = 0; i < nbytes; i++) begin
      rx_byte(sel, b, sok, sc);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (b !== e) begin
        failures++;
        $display("FAIL %s_byte%0d: got %h expected %h", tag, i, b, e);
      end
      checks++;
      if (!sok) begin
        failures++;
        $display("FAIL %s_stop%0d: stop bit got 0 expected 1", tag, i);
      end
    end
  endtask

  task automatic test_reset();
    rst0 = 1'b0; rst1 = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    w0 = '0; w1 = '0;
    repeat (3) tick();
    rst0 = 1'b1; rst1 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if ({tx0, ready0, busy0, done0} !== 4'b1100) begin
        failures++;
        $display("FAIL reset_idle0 cycle %0d: tx/ready/busy/done got %b expected 1100",
                 i, {tx0, ready0, busy0, done0});
      end
      checks++;
      if ({tx1, ready1, busy1, done1} !== 4'b1100) begin
        failures++;
        $display("FAIL reset_idle1 cycle %0d: tx/ready/busy/done got %b expected 1100",
                 i, {tx1, ready1, busy1, done1});
      end
    end
  endtask

  task automatic test_single_word();
    int n, bad;
    w0 = 32'h12345678;
    v0 = 1'b1;
    push_word(32'h12345678);
    tick();
    checks++;
    if ({tx0, ready0} !== 2'b10) begin
      failures++;
      $display("FAIL single_accept: tx/ready got %b expected 10", {tx0, ready0});
    end
    fork
      rx_and_compare(0, NB_SENT, "single");
      count_to_done(0, 2000, n);
      begin
        w0 = 32'hDEADBEEF;            // valid stays high while busy
        tick();
        checks++;
        if (tx0 !== 1'b0) begin
          failures++;
          $display("FAIL single_tx_latency: tx got %b expected 0", tx0);
        end
        repeat (98) tick();
        checks++;
        if ({busy0, ready0} !== 2'b10) begin
          failures++;
          $display("FAIL single_busy: busy/ready got %b expected 10", {busy0, ready0});
        end
        v0 = 1'b0;
      end
    join
    checks++;
    if (n !== DONE0) begin
      failures++;
      $display("FAIL single_done_time: got %0d expected %0d", n, DONE0);
    end
    checks++;
    if (ready0 !== 1'b1) begin
      failures++;
      $display("FAIL single_ready_in_done: got %b expected 1", ready0);
    end
    tick();
    checks++;
    if (done0 !== 1'b0) begin
      failures++;
      $display("FAIL single_done_width: got %b expected 0", done0);
    end
    bad = 0;
    repeat (60) begin
      tick();
      if (tx0 !== 1'b1 || ready0 !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL single_no_second_transfer: %0d active cycles expected 0", bad);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL single_queue_drained: %0d left expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int n1, n2, s0, s1;
    logic [7:0] b, e;
    bit sok;
    int sc;
    n1 = -1; n2 = -1; s0 = -1; s1 = -1;
    w0 = 32'hFFFFFFFF;
    v0 = 1'b1;
    push_word(32'hFFFFFFFF);
    tick();
    fork
      begin
        for (int i = 0; i < 2 * NB_SENT; i++) begin
          rx_byte(0, b, sok, sc);
          if (i == 0) s0 = sc;
          if (i == NB_SENT) s1 = sc;
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          checks++;
          if (b !== e || !sok) begin
            failures++;
            $display("FAIL b2b_byte%0d: got %h stop %0d expected %h stop 1", i, b, sok, e);
          end
        end
      end
      begin
        count_to_done(0, 2000, n1);
        w0 = 32'h00000001;
        push_word(32'h00000001);
        tick();
        v0 = 1'b0;
        checks++;
        if (busy0 !== 1'b1) begin
          failures++;
          $display("FAIL b2b_accept_in_done: busy got %b expected 1", busy0);
        end
        count_to_done(0, 2000, n2);
      end
    join
    checks++;
    if (n1 !== DONE0 || n2 !== DONE0) begin
      failures++;
      $display("FAIL b2b_done_time: got %0d,%0d expected %0d,%0d", n1, n2, DONE0, DONE0);
    end
    checks++;
    if (s1 - s0 !== FRAME0) begin
      failures++;
      $display("FAIL b2b_start_spacing: got %0d expected %0d", s1 - s0, FRAME0);
    end
    repeat (5) tick();
  endtask

  task automatic test_gap();
    int n, prev;
    logic [7:0] b, e;
    bit sok;
    int sc;
    n = -1;
    prev = -1;
    w1 = 32'hA5A5A5A5;
    v1 = 1'b1;
    push_word(32'hA5A5A5A5);
    tick();
    v1 = 1'b0;
    fork
      begin
        for (int i = 0; i < NB_SENT; i++) begin
          rx_byte(1, b, sok, sc);
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          checks++;
          if (b !== e || !sok) begin
            failures++;
            $display("FAIL gap_byte%0d: got %h stop %0d expected %h stop 1", i, b, sok, e);
          end
          if (i > 0) begin
            checks++;
            if (sc - prev !== BYTE_CYC + GAP * CPB) begin
              failures++;
              $display("FAIL gap_spacing%0d: got %0d expected %0d", i, sc - prev,
                       BYTE_CYC + GAP * CPB);
            end
          end
          prev = sc;
        end
      end
      count_to_done(1, 2000, n);
    join
    checks++;
    if (n !== DONE1) begin
      failures++;
      $display("FAIL gap_done_time: got %0d expected %0d", n, DONE1);
    end
    repeat (5) tick();
  endtask

  task automatic test_reset_mid();
    int bad, n;
    w0 = 32'hFFFF00FF;                // byte 1 all zero: tx low in its data bits
    v0 = 1'b1;
    tick();
    v0 = 1'b0;
    repeat (57) tick();               // inside data bit 3 of byte 1
    checks++;
    if (tx0 !== 1'b0) begin
      failures++;
      $display("FAIL midrst_pre_tx: got %b expected 0", tx0);
    end
    rst0 = 1'b0;
    tick();
    checks++;
    if ({tx0, ready0, busy0, done0} !== 4'b1100) begin
      failures++;
      $display("FAIL midrst_state: tx/ready/busy/done got %b expected 1100",
               {tx0, ready0, busy0, done0});
    end
    rst0 = 1'b1;
    bad = 0;
    repeat (200) begin
      tick();
      if (done0 !== 1'b0 || tx0 !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midrst_quiet: %0d bad cycles expected 0", bad);
    end
    w0 = 32'h0000CAFE;
    v0 = 1'b1;
    push_word(32'h0000CAFE);
    tick();
    v0 = 1'b0;
    fork
      rx_and_compare(0, NB_SENT, "after_rst");
      count_to_done(0, 2000, n);
    join
    checks++;
    if (n !== DONE0) begin
      failures++;
      $display("FAIL after_rst_done_time: got %0d expected %0d", n, DONE0);
    end
    repeat (5) tick();
  endtask

  task automatic test_checksum();
    int n;
    w0 = 32'h01020304;
    v0 = 1'b1;
    push_word(32'h01020304);
    tick();
    v0 = 1'b0;
    fork
      rx_and_compare(0, NB_SENT, "csum");
      count_to_done(0, 2000, n);
    join
    checks++;
    if (n !== DONE0) begin
      failures++;
      $display("FAIL csum_done_time: got %0d expected %0d", n, DONE0);
    end
    repeat (5) tick();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_gap();
    test_reset_mid();
    test_checksum();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
